// File: rtl/prt_pkg.sv
// Shared types and default sizing for the frame slot table.
package prt_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MEM_DEPTH  = 1518;
  localparam int DEF_NUM_SLOTS  = 4;

  typedef enum logic {
    W_IDLE,
    W_DATA
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_LOAD,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/prt_free_slot_enc.sv
// Lowest-index free slot picker plus free slot population count.
module prt_free_slot_enc #(
  parameter int  NUM_SLOTS = 4,
  localparam int SW        = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] avail,
  output logic [SW-1:0]        idx,
  output logic                 any,
  output logic [SW:0]          count
);

  // Scan high to low so the lowest available index wins; count in parallel.
  always_comb begin
    idx   = '0;
    any   = 1'b0;
    count = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (avail[i]) begin
        idx = SW'(i);
        any = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      count = count + {{SW{1'b0}}, avail[i]};
    end
  end

endmodule

// File: rtl/prt_slot_table.sv
// Frame slot table: one writer fills a free slot, one reader replays a
// committed slot, and slots are released only by explicit invalidation.
module prt_slot_table
  import prt_pkg::*;
#(
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int  NUM_SLOTS  = DEF_NUM_SLOTS,
  localparam int SW         = $clog2(NUM_SLOTS),
  localparam int LW         = $clog2(MEM_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_start_valid,
  output logic                  wr_start_ready,
  output logic [SW-1:0]         wr_slot,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic                  wr_done,
  output logic                  wr_err,
  input  logic                  rd_start_valid,
  input  logic [SW-1:0]         rd_start_slot,
  output logic                  rd_start_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  input  logic                  inv_valid,
  input  logic [SW-1:0]         inv_slot,
  output logic                  inv_ready,
  output logic [NUM_SLOTS-1:0]  valid_mask,
  output logic [SW:0]           free_count,
  output logic                  slot_free
);

  localparam int AW = $clog2(NUM_SLOTS * MEM_DEPTH);

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [NUM_SLOTS-1:0]         valid, reserved, avail;
  logic [NUM_SLOTS-1:0][LW-1:0] length;
  logic [SW-1:0]                free_idx, rslot;
  logic [LW-1:0]                wcnt, rcnt;
  logic [AW-1:0]                waddr, raddr;
  logic [DATA_WIDTH-1:0]        mem [NUM_SLOTS*MEM_DEPTH];
  logic [DATA_WIDTH-1:0]        mem_q;
  logic wr_start_fire, wr_fire, commit, overflow, wr_full;
  logic rd_start_fire, rd_en, rd_end, inv_fire;

  assign avail      = ~valid & ~reserved;
  assign valid_mask = valid;

  prt_free_slot_enc #(.NUM_SLOTS(NUM_SLOTS)) u_free (
    .avail (avail),
    .idx   (free_idx),
    .any   (slot_free),
    .count (free_count)
  );

  assign wr_full       = (wcnt == LW'(MEM_DEPTH - 1));
  assign wr_start_fire = wr_start_valid && wr_start_ready;
  assign wr_fire       = wr_valid && wr_ready;
  assign commit        = wr_fire && wr_last;
  assign overflow      = wr_fire && !wr_last && wr_full;
  assign rd_start_fire = rd_start_valid && rd_start_ready;
  assign rd_end        = (r_state == R_DATA) && rd_ready && rd_last;
  assign inv_fire      = inv_valid && inv_ready;

  // Flat memory: each slot owns a contiguous MEM_DEPTH-word window.
  assign waddr = AW'(wr_slot) * AW'(MEM_DEPTH) + AW'(wcnt);
  assign raddr = AW'(rslot) * AW'(MEM_DEPTH) + AW'(rcnt);

  // State registers for both engines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  // Write engine: open handshake, then accept beats until last or full.
  always_comb begin
    w_next         = w_state;
    wr_start_ready = 1'b0;
    wr_ready       = 1'b0;
    case (w_state)
      W_IDLE: begin
        wr_start_ready = slot_free;
        if (wr_start_valid && slot_free) w_next = W_DATA;
      end
      W_DATA: begin
        wr_ready = 1'b1;
        if (wr_valid && (wr_last || wr_full)) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read engine: one load cycle primes the RAM output, then stream.
  // inv_ready only blocks release of the slot currently being read.
  always_comb begin
    r_next         = r_state;
    rd_start_ready = 1'b0;
    rd_en          = 1'b0;
    inv_ready      = !((r_state != R_IDLE) && (inv_slot == rslot));
    case (r_state)
      R_IDLE: begin
        rd_start_ready = valid[rd_start_slot];
        if (rd_start_valid && valid[rd_start_slot]) r_next = R_LOAD;
      end
      R_LOAD: begin
        rd_en  = 1'b1;
        r_next = R_DATA;
      end
      R_DATA: begin
        if (rd_ready) begin
          if (rd_last) r_next = R_IDLE;
          else         rd_en  = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Write-side bookkeeping: allocated slot, beat counter, status pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_slot <= '0;
      wcnt    <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      wr_done <= commit;
      wr_err  <= overflow;
      if (wr_start_fire) begin
        wr_slot <= free_idx;
        wcnt    <= '0;
      end else if (wr_fire) begin
        wcnt <= wcnt + LW'(1);
      end
    end
  end

  // Per-slot table; commit, overflow drop and invalidate may coincide on
  // distinct slots and all land on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid    <= '0;
      reserved <= '0;
      length   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_start_fire && free_idx == SW'(i)) reserved[i] <= 1'b1;
        if ((commit || overflow) && wr_slot == SW'(i)) reserved[i] <= 1'b0;
        if (commit && wr_slot == SW'(i)) begin
          valid[i]  <= 1'b1;
          length[i] <= wcnt + LW'(1);
        end
        if (inv_fire && inv_slot == SW'(i) && valid[i]) begin
          valid[i]  <= 1'b0;
          length[i] <= '0;
        end
      end
    end
  end

  // Read-side bookkeeping: latched slot, beat index, output valid/last.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rslot    <= '0;
      rcnt     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (rd_start_fire) begin
        rslot <= rd_start_slot;
        rcnt  <= '0;
      end
      if (rd_en) begin
        rcnt     <= rcnt + LW'(1);
        rd_valid <= 1'b1;
        rd_last  <= (rcnt == length[rslot] - LW'(1));
      end else if (rd_end) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  // Beat storage write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_fire) mem[waddr] <= wr_data;
  end

  // Synchronous read port; enable gating holds the beat during stalls.
  always_ff @(posedge CLK) begin
    if (rd_en) mem_q <= mem[raddr];
  end

  assign rd_data = rd_valid ? mem_q : '0;

endmodule

// File: tb/tb_prt_slot_table.sv
// Directed bench for prt_slot_table (4 slots, 16-beat depth).
module tb_prt_slot_table;

  localparam int DW = 8;
  localparam int MD = 16;
  localparam int NS = 4;
  localparam int SW = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          wr_start_valid, wr_start_ready;
  logic [SW-1:0] wr_slot;
  logic [DW-1:0] wr_data;
  logic          wr_last, wr_valid, wr_ready, wr_done, wr_err;
  logic          rd_start_valid, rd_start_ready;
  logic [SW-1:0] rd_start_slot;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          inv_valid, inv_ready;
  logic [SW-1:0] inv_slot;
  logic [NS-1:0] valid_mask;
  logic [SW:0]   free_count;
  logic          slot_free;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rq[$];
  int         rlast_pos, hold_bad, rcycles;
  bit         rd_to;

  prt_slot_table #(.DATA_WIDTH(DW), .MEM_DEPTH(MD), .NUM_SLOTS(NS)) dut (
    .CLK(CLK), .RST(RST),
    .wr_start_valid(wr_start_valid), .wr_start_ready(wr_start_ready), .wr_slot(wr_slot),
    .wr_data(wr_data), .wr_last(wr_last), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_done(wr_done), .wr_err(wr_err),
    .rd_start_valid(rd_start_valid), .rd_start_slot(rd_start_slot), .rd_start_ready(rd_start_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .inv_valid(inv_valid), .inv_slot(inv_slot), .inv_ready(inv_ready),
    .valid_mask(valid_mask), .free_count(free_count), .slot_free(slot_free)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_open;
    wr_start_valid = 1'b1;
    tick();
    wr_start_valid = 1'b0;
  endtask

  task automatic do_beats(input int n, input logic [7:0] base, input bit last);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
      wr_last  = last && (i == n - 1);
      tick();
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Opens a read and collects beats; rd_ready follows pat[cycle % 4].
  task automatic read_slot(input logic [SW-1:0] s, input logic [3:0] pat);
    logic [7:0] prev;
    bit         stalled, done;
    rq.delete();
    rlast_pos = -1; hold_bad = 0; rcycles = 0; rd_to = 1'b1;
    stalled = 1'b0; done = 1'b0; prev = '0;
    rd_start_slot = s;
    rd_start_valid = 1'b1;
    tick();
    rd_start_valid = 1'b0;
    for (int c = 0; c < 64; c++) begin
      rd_ready = pat[c % 4];
      #3;
      if (stalled && rd_data !== prev) hold_bad++;
      if (rd_valid && rd_ready) begin
        rq.push_back(rd_data);
        if (rd_last && rlast_pos < 0) rlast_pos = rq.size() - 1;
        done    = rd_last;
        stalled = 1'b0;
      end else begin
        stalled = rd_valid;
        prev    = rd_data;
      end
      @(posedge CLK);
      #1;
      rcycles++;
      if (done) begin
        rd_to = 1'b0;
        break;
      end
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick(); tick();
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
    n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
    n_vec++; if (wr_done !== 1'b0 || wr_err !== 1'b0) begin n_err++; $display("FAIL rst_pulses got %b%b want 00", wr_done, wr_err); end
    n_vec++; if (wr_slot !== 2'd0) begin n_err++; $display("FAIL rst_wr_slot got %0d want 0", wr_slot); end
    RST = 1'b0;
    #1;
    n_vec++; if (valid_mask !== 4'b0000) begin n_err++; $display("FAIL rst_valid_mask got %b want 0000", valid_mask); end
    n_vec++; if (free_count !== 3'd4) begin n_err++; $display("FAIL rst_free_count got %0d want 4", free_count); end
    n_vec++; if (slot_free !== 1'b1 || inv_ready !== 1'b1) begin n_err++; $display("FAIL rst_free_inv got %b%b want 11", slot_free, inv_ready); end
    n_vec++; if (wr_start_ready !== 1'b1) begin n_err++; $display("FAIL rst_wr_start_ready got %b want 1", wr_start_ready); end
    n_vec++; if (rd_start_ready !== 1'b0) begin n_err++; $display("FAIL rst_rd_start_ready got %b want 0", rd_start_ready); end
    tick();
  endtask

  task automatic test_write_read;
    int bad;
    do_open();
    n_vec++; if (wr_slot !== 2'd0) begin n_err++; $display("FAIL wr1_slot got %0d want 0", wr_slot); end
    do_beats(5, 8'h11, 1'b1);
    n_vec++; if (wr_done !== 1'b1) begin n_err++; $display("FAIL wr1_done got %b want 1", wr_done); end
    n_vec++; if (valid_mask !== 4'b0001) begin n_err++; $display("FAIL wr1_mask got %b want 0001", valid_mask); end
    n_vec++; if (free_count !== 3'd3) begin n_err++; $display("FAIL wr1_free got %0d want 3", free_count); end
    tick();
    n_vec++; if (wr_done !== 1'b0) begin n_err++; $display("FAIL wr1_done_pulse got %b want 0", wr_done); end
    read_slot(2'd0, 4'b1111);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h11 + 8'(i)) bad++;
    n_vec++; if (rq.size() != 5 || bad != 0) begin n_err++; $display("FAIL rd1_data got %0d beats/%0d wrong want 5/0", rq.size(), bad); end
    n_vec++; if (rlast_pos != 4) begin n_err++; $display("FAIL rd1_last got pos %0d want 4", rlast_pos); end
    n_vec++; if (rcycles != 6 || rd_to) begin n_err++; $display("FAIL rd1_b2b got %0d cycles want 6", rcycles); end
  endtask

  task automatic test_fill_and_realloc;
    for (int k = 1; k < 4; k++) begin
      do_open();
      n_vec++; if (wr_slot !== 2'(k)) begin n_err++; $display("FAIL fill_slot got %0d want %0d", wr_slot, k); end
      do_beats(3, 8'h21 + 8'(16 * (k - 1)), 1'b1);
    end
    n_vec++; if (slot_free !== 1'b0 || wr_start_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b%b want 00", slot_free, wr_start_ready); end
    n_vec++; if (free_count !== 3'd0 || valid_mask !== 4'b1111) begin n_err++; $display("FAIL full_status got %0d/%b want 0/1111", free_count, valid_mask); end
    inv_slot = 2'd2; inv_valid = 1'b1;
    #1;
    n_vec++; if (inv_ready !== 1'b1) begin n_err++; $display("FAIL inv2_ready got %b want 1", inv_ready); end
    tick();
    inv_valid = 1'b0;
    n_vec++; if (valid_mask !== 4'b1011 || free_count !== 3'd1) begin n_err++; $display("FAIL inv2_status got %b/%0d want 1011/1", valid_mask, free_count); end
    do_open();
    n_vec++; if (wr_slot !== 2'd2) begin n_err++; $display("FAIL realloc_slot got %0d want 2", wr_slot); end
    do_beats(2, 8'h51, 1'b1);
    n_vec++; if (valid_mask !== 4'b1111) begin n_err++; $display("FAIL realloc_mask got %b want 1111", valid_mask); end
  endtask

  task automatic test_overflow;
    inv_slot = 2'd3; inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
    do_open();
    n_vec++; if (wr_slot !== 2'd3 || free_count !== 3'd0) begin n_err++; $display("FAIL ovf_open got %0d/%0d want 3/0", wr_slot, free_count); end
    do_beats(16, 8'h60, 1'b0);
    n_vec++; if (wr_err !== 1'b1 || wr_done !== 1'b0) begin n_err++; $display("FAIL ovf_pulse got err=%b done=%b want 1/0", wr_err, wr_done); end
    n_vec++; if (valid_mask !== 4'b0111 || free_count !== 3'd1) begin n_err++; $display("FAIL ovf_status got %b/%0d want 0111/1", valid_mask, free_count); end
    n_vec++; if (wr_ready !== 1'b0 || wr_start_ready !== 1'b1) begin n_err++; $display("FAIL ovf_idle got %b%b want 01", wr_ready, wr_start_ready); end
    tick();
    n_vec++; if (wr_err !== 1'b0) begin n_err++; $display("FAIL ovf_err_pulse got %b want 0", wr_err); end
  endtask

  task automatic test_stall_read;
    int bad;
    read_slot(2'd1, 4'b1001);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h21 + 8'(i)) bad++;
    n_vec++; if (rq.size() != 3 || bad != 0) begin n_err++; $display("FAIL stall_data got %0d beats/%0d wrong want 3/0", rq.size(), bad); end
    n_vec++; if (hold_bad != 0) begin n_err++; $display("FAIL stall_hold got %0d changes want 0", hold_bad); end
    n_vec++; if (rlast_pos != 2 || rcycles != 8 || rd_to) begin n_err++; $display("FAIL stall_timing got last %0d cycles %0d want 2/8", rlast_pos, rcycles); end
  endtask

  task automatic test_inv_during_read;
    int         bad_ir, bad;
    logic [4:0] done_seen, last_seen;
    bad_ir = 0; done_seen = '0; last_seen = '0;
    rq.delete();
    wr_start_valid = 1'b1; rd_start_valid = 1'b1; rd_start_slot = 2'd1;
    rd_ready = 1'b1; inv_slot = 2'd1;
    tick();
    wr_start_valid = 1'b0; rd_start_valid = 1'b0;
    n_vec++; if (wr_slot !== 2'd3) begin n_err++; $display("FAIL cc_wr_slot got %0d want 3", wr_slot); end
    for (int c = 0; c < 5; c++) begin
      wr_valid = (c < 3);
      wr_data  = 8'h71 + 8'(c);
      wr_last  = (c == 2);
      inv_valid = 1'b1;
      #3;
      if (inv_ready !== (c >= 4)) bad_ir++;
      done_seen[c] = wr_done;
      if (rd_valid && rd_ready) begin
        rq.push_back(rd_data);
        last_seen[c] = rd_last;
      end
      tick();
    end
    inv_valid = 1'b0; wr_valid = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
    n_vec++; if (bad_ir != 0) begin n_err++; $display("FAIL cc_inv_ready got %0d wrong cycles want 0", bad_ir); end
    n_vec++; if (done_seen !== 5'b01000) begin n_err++; $display("FAIL cc_wr_done got %b want 01000", done_seen); end
    n_vec++; if (last_seen !== 5'b01000) begin n_err++; $display("FAIL cc_rd_last got %b want 01000", last_seen); end
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h21 + 8'(i)) bad++;
    n_vec++; if (rq.size() != 3 || bad != 0) begin n_err++; $display("FAIL cc_rd_data got %0d beats/%0d wrong want 3/0", rq.size(), bad); end
    n_vec++; if (valid_mask !== 4'b1101) begin n_err++; $display("FAIL cc_mask got %b want 1101", valid_mask); end
    read_slot(2'd3, 4'b1111);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h71 + 8'(i)) bad++;
    n_vec++; if (rq.size() != 3 || bad != 0 || rlast_pos != 2) begin n_err++; $display("FAIL cc_slot3 got %0d beats/%0d wrong/last %0d want 3/0/2", rq.size(), bad, rlast_pos); end
  endtask

  task automatic test_mid_reset;
    int bad;
    inv_slot = 2'd0; inv_valid = 1'b1;
    tick();
    inv_valid = 1'b0;
    wr_start_valid = 1'b1; rd_start_valid = 1'b1; rd_start_slot = 2'd2; rd_ready = 1'b0;
    tick();
    wr_start_valid = 1'b0; rd_start_valid = 1'b0;
    n_vec++; if (wr_slot !== 2'd0) begin n_err++; $display("FAIL mr_slot got %0d want 0", wr_slot); end
    do_beats(3, 8'h81, 1'b0);
    n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL mr_rd_open got %b want 1", rd_valid); end
    wr_valid = 1'b1; wr_data = 8'h84;
    #2;
    RST = 1'b1;
    #1;
    n_vec++; if (valid_mask !== 4'b0000 || free_count !== 3'd4) begin n_err++; $display("FAIL mr_status got %b/%0d want 0000/4", valid_mask, free_count); end
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_err++; $display("FAIL mr_rd got %b/%h want 0/00", rd_valid, rd_data); end
    n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL mr_wr_ready got %b want 0", wr_ready); end
    wr_valid = 1'b0;
    tick();
    RST = 1'b0;
    #1;
    n_vec++; if (wr_start_ready !== 1'b1 || slot_free !== 1'b1) begin n_err++; $display("FAIL mr_recover got %b%b want 11", wr_start_ready, slot_free); end
    tick();
    do_open();
    n_vec++; if (wr_slot !== 2'd0) begin n_err++; $display("FAIL mr_reopen got %0d want 0", wr_slot); end
    do_beats(2, 8'h91, 1'b1);
    read_slot(2'd0, 4'b1111);
    bad = 0;
    foreach (rq[i]) if (rq[i] !== 8'h91 + 8'(i)) bad++;
    n_vec++; if (rq.size() != 2 || bad != 0 || rlast_pos != 1) begin n_err++; $display("FAIL mr_readback got %0d beats/%0d wrong/last %0d want 2/0/1", rq.size(), bad, rlast_pos); end
  endtask

  initial begin
    RST = 1'b1;
    wr_start_valid = 1'b0; wr_data = '0; wr_last = 1'b0; wr_valid = 1'b0;
    rd_start_valid = 1'b0; rd_start_slot = '0; rd_ready = 1'b0;
    inv_valid = 1'b0; inv_slot = '0;
    test_reset();
    test_write_read();
    test_fill_and_realloc();
    test_overflow();
    test_stall_read();
    test_inv_during_read();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prt_slot_table.md
PRT_SLOT_TABLE -- requirements
Module: prt_slot_table

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning frame beat width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 1518, meaning max beats per slot.
REQ-003 SHALL have parameter NUM_SLOTS, default 4, meaning slot count (any value >= 2); SW = $clog2(NUM_SLOTS), LW = $clog2(MEM_DEPTH+1).
REQ-004 SHALL have port CLK  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wr_start_valid in 1 / wr_start_ready out 1 / wr_slot out SW  write-open handshake and allocated slot.
REQ-007 SHALL have ports wr_data in DATA_WIDTH / wr_last in 1 / wr_valid in 1 / wr_ready out 1  write beat stream.
REQ-008 SHALL have ports wr_done out 1 / wr_err out 1  one-cycle commit and overflow pulses.
REQ-009 SHALL have ports rd_start_valid in 1 / rd_start_slot in SW / rd_start_ready out 1  read-open handshake.
REQ-010 SHALL have ports rd_data out DATA_WIDTH / rd_last out 1 / rd_valid out 1 / rd_ready in 1  read beat stream.
REQ-011 SHALL have ports inv_valid in 1 / inv_slot in SW / inv_ready out 1  slot release handshake.
REQ-012 SHALL have ports valid_mask out NUM_SLOTS / free_count out SW+1 / slot_free out 1  table status.

Function
REQ-013 SHALL run independent write FSM (W_IDLE, W_DATA) and read FSM (R_IDLE, R_LOAD, R_DATA) so one write and one read proceed concurrently on different slots.
REQ-014 SHALL store beats in one memory of NUM_SLOTS*MEM_DEPTH words, one write port, one synchronous read port (1-cycle latency); per slot keep valid, reserved, length[LW].
REQ-015 SHALL select free slot as lowest index with valid=0 and reserved=0; slot_free = any such slot; free_count = number of such slots.
REQ-016 SHALL assert wr_start_ready = W_IDLE && slot_free; handshake sets reserved, drives wr_slot (held until next open), beat counter=0, W_DATA next cycle.
REQ-017 SHALL assert wr_ready=1 throughout W_DATA; each wr_valid&&wr_ready writes beat at counter, counter+1.
REQ-018 SHALL on beat with wr_last=1: next cycle pulse wr_done, set valid, clear reserved, length=counter+1, return W_IDLE.
REQ-019 SHALL on MEM_DEPTH-th beat without wr_last: next cycle pulse wr_err, clear reserved, leave valid=0, return W_IDLE (frame dropped); wr_last on that beat is a normal commit.
REQ-020 SHALL assert rd_start_ready = R_IDLE && valid[rd_start_slot]; handshake in cycle N latches slot, R_LOAD, rd_valid=1 with beat 0 at N+2.
REQ-021 SHALL in R_DATA hold rd_data/rd_last stable while rd_valid && !rd_ready, sustain one beat per cycle while rd_ready=1, rd_last=1 on beat length-1, R_IDLE after that beat handshakes.
REQ-022 SHALL leave a slot valid after reading; only invalidation frees it.
REQ-023 SHALL assert inv_ready=1 except when inv_slot equals slot in R_LOAD/R_DATA; handshake clears valid and length next cycle; invalid or reserved target is a no-op (reserved bit untouched); no memory wipe.
REQ-024 SHALL apply same-cycle commit, invalidate and read-open on distinct slots all together; commit and freed slot visible to allocation next cycle.
REQ-025 SHALL make wr_start_ready/rd_start_ready/inv_ready combinational on state only, not on the matching valid.

Reset
REQ-026 SHALL while RST=1: both FSMs idle, all valid/reserved/length cleared, wr_slot=0, wr_done=wr_err=0, wr_ready=0, rd_valid=rd_last=0, rd_data=0.
REQ-027 SHALL after reset: valid_mask=0, free_count=NUM_SLOTS, slot_free=1, inv_ready=1; memory contents undefined, not cleared.
REQ-028 SHALL abandon in-flight write (slot not committed) and read on mid-operation reset.

Structure
REQ-029 SHALL place w_state_t, r_state_t and default parameter constants in package prt_pkg.
REQ-030 SHALL put lowest-free priority encoder and popcount in sub-module prt_free_slot_enc (parametrised NUM_SLOTS).

Verification
REQ-031 SHALL test: NUM_SLOTS=4, write 5 beats 0x11..0x15 last on 5th -> wr_slot=0, wr_done 1 cycle, valid_mask=0001, free_count=3; read slot 0 with rd_ready=1 -> 0x11..0x15 back-to-back, rd_last on 0x15.
REQ-032 SHALL test: fill 4 slots -> slot_free=0, wr_start_ready=0; invalidate slot 2 -> next open gets wr_slot=2.
REQ-033 SHALL test: MEM_DEPTH=16, 16 beats no wr_last -> wr_err pulse, valid_mask unchanged, free_count restored.
REQ-034 SHALL test: read slot 1 toggling rd_ready 1,0,0,1 -> rd_data held during stalls, no beat lost or duplicated.
REQ-035 SHALL test: invalidate slot 1 during its read -> inv_ready=0 until rd_last handshake, then slot 1 cleared; concurrent write to slot 3 commits correctly.
REQ-036 SHALL test: RST pulse mid-write of slot 0 beat 3 -> valid_mask=0, free_count=4, rd_valid=0.
